// File: rtl/prm_pkg.sv
// Shared definitions for the edge-mask accumulator slice: FSM encoding,
// default widths and the word-index width helper.
package prm_pkg;

  // Accumulator control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    EMIT  = 2'd3
  } prm_state_e;

  // Voxel code width: checker inputs A..O, A = bit 0.
  localparam int PRM_VOX_W  = 15;
  // Default number of checked edges (checker instances).
  localparam int PRM_N_EDGE = 512;
  // Default bitmap output word width.
  localparam int PRM_OUT_W  = 32;
  // Default voxel counter width.
  localparam int PRM_CNT_W  = 16;

  // Width of a word index over n_word words; never narrower than one bit.
  function automatic int prm_idx_w(input int n_word);
    return (n_word > 1) ? $clog2(n_word) : 1;
  endfunction

endpackage

// File: rtl/prm_mask_word_sel.sv
// Combinational word mux: picks OUT_W-bit word idx out of the accumulated
// per-edge blocked bitmap.
module prm_mask_word_sel
  import prm_pkg::*;
#(
  parameter int N_EDGE = PRM_N_EDGE,
  parameter int OUT_W  = PRM_OUT_W,
  localparam int N_WORD = N_EDGE / OUT_W,
  localparam int IDX_W  = prm_idx_w(N_WORD)
) (
  input  logic [N_EDGE-1:0] acc,
  input  logic [IDX_W-1:0]  idx,
  output logic [OUT_W-1:0]  word
);

  // Select the indexed word; out-of-range indices read as zero.
  always_comb begin
    word = '0;
    for (int unsigned w = 0; w < N_WORD; w++) begin
      if (idx == IDX_W'(w)) begin
        word = acc[w*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Edge-mask accumulator: registers each occupied-voxel code to drive the
// external checker bank, ORs the returned edge mask over a whole obstacle
// frame, then emits the blocked-edge bitmap word by word over valid/ready.
module prm_edge_mask_accum
  import prm_pkg::*;
#(
  parameter int N_EDGE = PRM_N_EDGE,
  parameter int VOX_W  = PRM_VOX_W,
  parameter int OUT_W  = PRM_OUT_W,
  parameter int CNT_W  = PRM_CNT_W,
  localparam int N_WORD = N_EDGE / OUT_W,
  localparam int IDX_W  = prm_idx_w(N_WORD)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frm_start,
  input  logic              vox_valid,
  output logic              vox_ready,
  input  logic [VOX_W-1:0]  vox_code,
  input  logic              vox_last,
  output logic [VOX_W-1:0]  chk_code,
  input  logic [N_EDGE-1:0] chk_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  vox_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORD - 1);

  prm_state_e        state_q, state_d;
  logic [VOX_W-1:0]  chk_code_q, chk_code_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_EDGE-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              accept;
  logic              word_done;
  logic [OUT_W-1:0]  sel_word;

  assign accept    = vox_valid && vox_ready;
  assign word_done = (state_q == EMIT) && out_ready;

  // Word mux over the accumulated bitmap.
  prm_mask_word_sel #(
    .N_EDGE (N_EDGE),
    .OUT_W  (OUT_W)
  ) u_word_sel (
    .acc  (acc_q),
    .idx  (idx_q),
    .word (sel_word)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      chk_code_q <= '0;
      vld_q      <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      chk_code_q <= chk_code_d;
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
    end
  end

  // Next-state logic; frm_start outranks any voxel offered in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frm_start) state_d = ACCUM;
      ACCUM:   if (!frm_start && accept && vox_last) state_d = FLUSH;
      FLUSH:   state_d = EMIT;
      EMIT:    if (word_done && (idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: voxel capture, mask OR one cycle behind, word index.
  always_comb begin
    chk_code_d = chk_code_q;
    vld_d      = vld_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    case (state_q)
      IDLE: begin
        if (frm_start) begin
          acc_d = '0;
          cnt_d = '0;
          vld_d = 1'b0;
          idx_d = '0;
        end
      end
      ACCUM: begin
        if (frm_start) begin
          // Restart drops the pending mask and any voxel offered this cycle.
          acc_d = '0;
          cnt_d = '0;
          vld_d = 1'b0;
        end else begin
          if (vld_q) begin
            acc_d = acc_q | chk_mask;
          end
          vld_d = accept;
          if (accept) begin
            chk_code_d = vox_code;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        // Fold in the mask of the final voxel captured in ACCUM.
        if (vld_q) begin
          acc_d = acc_q | chk_mask;
        end
        vld_d = 1'b0;
        idx_d = '0;
      end
      EMIT: begin
        if (word_done) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        vld_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    vox_ready = (state_q == ACCUM);
    out_valid = (state_q == EMIT);
    busy      = (state_q != IDLE);
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_data  = out_valid ? sel_word : '0;
    out_idx   = idx_q;
    chk_code  = chk_code_q;
    vox_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Self-checking bench for prm_edge_mask_accum with a one-hot stub checker
// bank (edge i blocked when chk_code[5:0] == i), N_EDGE=64, OUT_W=32, CNT_W=4.
module tb_prm_edge_mask_accum;

  localparam int N_EDGE = 64;
  localparam int OUT_W  = 32;
  localparam int VOX_W  = 15;
  localparam int CNT_W  = 4;
  localparam int N_WORD = N_EDGE / OUT_W;
  localparam int CNT_MAX = 15;

  logic              CLK = 1'b0;
  logic              RST;
  logic              frm_start;
  logic              vox_valid;
  logic              vox_ready;
  logic [VOX_W-1:0]  vox_code;
  logic              vox_last;
  logic [VOX_W-1:0]  chk_code;
  logic [N_EDGE-1:0] chk_mask;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [0:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  vox_cnt;

  always #5 CLK = ~CLK;

  // Stub checker bank: purely combinational one-hot on the low six code bits.
  assign chk_mask = 64'd1 << chk_code[5:0];

  prm_edge_mask_accum #(
    .N_EDGE (N_EDGE),
    .VOX_W  (VOX_W),
    .OUT_W  (OUT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .frm_start (frm_start),
    .vox_valid (vox_valid),
    .vox_ready (vox_ready),
    .vox_code  (vox_code),
    .vox_last  (vox_last),
    .chk_code  (chk_code),
    .chk_mask  (chk_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .vox_cnt   (vox_cnt)
  );

  // Reference model state (written by the stimulus thread only).
  logic [VOX_W-1:0] model_codes[$];
  int               model_n = 0;
  logic [OUT_W-1:0] exp_words [N_WORD];
  int               hs_target = 0;
  int               frame_base = 0;
  bit               lit_en = 1'b0;
  logic [OUT_W-1:0] lit_w [N_WORD];
  logic [CNT_W-1:0] lit_cnt = '0;

  // Compare-process state.
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int stall  = 0;
  int vwait  = 0;
  bit prev_rst = 1'b0;
  bit done_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks outputs against the model every cycle.
  initial begin
    int widx;
    int sat;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_rst = 1'b1;
        stall    = 0;
        vwait    = 0;
        done_pending = 1'b0;
      end else begin
        if (prev_rst) begin
          chk("rst_out_valid", 64'(out_valid), 64'd0);
          chk("rst_busy",      64'(busy),      64'd0);
          chk("rst_vox_ready", 64'(vox_ready), 64'd0);
          chk("rst_out_data",  64'(out_data),  64'd0);
          chk("rst_out_idx",   64'(out_idx),   64'd0);
          chk("rst_out_last",  64'(out_last),  64'd0);
          chk("rst_chk_code",  64'(chk_code),  64'd0);
          prev_rst = 1'b0;
        end
        sat = (model_n > CNT_MAX) ? CNT_MAX : model_n;
        chk("vox_cnt", 64'(vox_cnt), 64'(sat));
        if (done_pending) begin
          chk("idle_busy",      64'(busy),      64'd0);
          chk("idle_out_valid", 64'(out_valid), 64'd0);
          done_pending = 1'b0;
        end
        if (out_valid) begin
          if (hs_cnt >= hs_target) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            widx = hs_cnt - frame_base;
            chk("out_idx",   64'(out_idx),   64'(widx));
            chk("out_data",  64'(out_data),  64'(exp_words[widx]));
            chk("out_last",  64'(out_last),  64'(widx == N_WORD - 1));
            chk("emit_vox_ready", 64'(vox_ready), 64'd0);
            chk("emit_busy", 64'(busy), 64'd1);
            if (lit_en) chk("lit_word", 64'(out_data), 64'(lit_w[widx]));
            if (out_ready) begin
              hs_cnt++;
              stall = 0;
              if (widx == N_WORD - 1) begin
                done_pending = 1'b1;
                if (lit_en) chk("lit_vox_cnt", 64'(vox_cnt), 64'(lit_cnt));
              end
            end else begin
              stall++;
            end
          end
        end else if (hs_cnt < hs_target) begin
          stall++;
        end
        if (stall == 300) chk("drain_timeout", 64'(out_valid && out_ready), 64'd1);
        if (vox_valid && !vox_ready) vwait++; else vwait = 0;
        if (vwait == 50) chk("vox_ready_timeout", 64'(vox_ready), 64'd1);
      end
    end
  end

  // One clock: sample the voxel handshake mid-cycle, return just after the edge.
  task automatic cycle(output bit acc);
    @(negedge CLK);
    acc = vox_valid && vox_ready && !frm_start && !RST;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame(input bit with_vox, input logic [VOX_W-1:0] c);
    bit a;
    frm_start = 1'b1;
    vox_valid = with_vox;
    vox_code  = c;
    cycle(a);
    frm_start = 1'b0;
    vox_valid = 1'b0;
    model_codes.delete();
    model_n = 0;
  endtask

  // Expected bitmap: OR of one-hot edges over every accepted voxel this frame.
  task automatic finish_frame();
    logic [N_EDGE-1:0] bm;
    logic [5:0] e;
    bm = '0;
    foreach (model_codes[i]) begin
      e = model_codes[i][5:0];
      bm[e] = 1'b1;
    end
    for (int w = 0; w < N_WORD; w++) exp_words[w] = bm[w*OUT_W +: OUT_W];
    frame_base = hs_cnt;
    hs_target  = hs_cnt + N_WORD;
  endtask

  task automatic send_voxel(input logic [VOX_W-1:0] c, input bit last, input int gap);
    bit a;
    int n;
    vox_valid = 1'b0;
    vox_last  = 1'b0;
    for (int i = 0; i < gap; i++) cycle(a);
    vox_valid = 1'b1;
    vox_code  = c;
    vox_last  = last;
    n = 0;
    a = 1'b0;
    while (!a && n < 60) begin
      cycle(a);
      n++;
    end
    vox_valid = 1'b0;
    vox_last  = 1'b0;
    if (a) begin
      model_codes.push_back(c);
      model_n++;
      if (last) finish_frame();
    end
  endtask

  task automatic drain(input int hold, input bit rnd, input bit fs_all);
    bit a;
    int n;
    n = 0;
    while (hs_cnt < hs_target && n < 400) begin
      if (n < hold) out_ready = 1'b0;
      else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      frm_start = fs_all || (rnd && ($urandom_range(0, 5) == 0));
      cycle(a);
      n++;
    end
    frm_start = 1'b0;
    out_ready = 1'b0;
    cycle(a);
  endtask

  task automatic set_lit(input logic [OUT_W-1:0] w0, input logic [OUT_W-1:0] w1,
                         input logic [CNT_W-1:0] c);
    lit_en   = 1'b1;
    lit_w[0] = w0;
    lit_w[1] = w1;
    lit_cnt  = c;
  endtask

  task automatic do_reset();
    bit a;
    RST       = 1'b1;
    frm_start = 1'b0;
    vox_valid = 1'b0;
    vox_last  = 1'b0;
    out_ready = 1'b0;
    hs_target = hs_cnt;
    model_codes.delete();
    model_n   = 0;
    lit_en    = 1'b0;
    cycle(a);
    RST = 1'b0;
  endtask

  // Stimulus thread.
  initial begin
    bit a;
    int nv;
    RST = 1'b1;
    frm_start = 1'b0;
    vox_valid = 1'b0;
    vox_code  = '0;
    vox_last  = 1'b0;
    out_ready = 1'b0;
    cycle(a);
    cycle(a);
    RST = 1'b0;
    cycle(a);

    // Basic frame, frm_start held through FLUSH/EMIT and the last handshake.
    set_lit(32'h0000_0008, 32'h0000_0100, 4'd3);
    start_frame(1'b0, 15'd0);
    send_voxel(15'd3, 1'b0, 0);
    send_voxel(15'd40, 1'b0, 0);
    send_voxel(15'd3, 1'b1, 0);
    drain(0, 1'b0, 1'b1);
    lit_en = 1'b0;

    // Backpressure on word0.
    set_lit(32'h0000_0008, 32'h0000_0100, 4'd3);
    start_frame(1'b0, 15'd0);
    send_voxel(15'd3, 1'b0, 0);
    send_voxel(15'd40, 1'b0, 0);
    send_voxel(15'd3, 1'b1, 0);
    drain(7, 1'b0, 1'b0);
    lit_en = 1'b0;

    // Restart with a simultaneous voxel that must be discarded.
    set_lit(32'h0000_0200, 32'h0000_0000, 4'd1);
    start_frame(1'b0, 15'd0);
    send_voxel(15'd5, 1'b0, 0);
    start_frame(1'b1, 15'd7);
    send_voxel(15'd9, 1'b1, 0);
    drain(0, 1'b0, 1'b0);
    lit_en = 1'b0;

    // Reset while word0 is pending, then a fresh frame.
    start_frame(1'b0, 15'd0);
    send_voxel(15'd3, 1'b1, 0);
    out_ready = 1'b0;
    repeat (3) cycle(a);
    do_reset();
    cycle(a);
    set_lit(32'h0000_0001, 32'h0000_0000, 4'd1);
    start_frame(1'b0, 15'd0);
    send_voxel(15'd0, 1'b1, 0);
    drain(0, 1'b0, 1'b0);
    lit_en = 1'b0;

    // Gapped input, edges at both ends of word1.
    set_lit(32'h0000_0000, 32'h8000_0001, 4'd2);
    start_frame(1'b0, 15'd0);
    send_voxel(15'd63, 1'b0, 3);
    send_voxel(15'd32, 1'b1, 3);
    drain(0, 1'b0, 1'b0);
    lit_en = 1'b0;

    // Counter saturation.
    set_lit(32'h0000_0002, 32'h0000_0000, 4'hF);
    start_frame(1'b0, 15'd0);
    for (int i = 0; i < 20; i++) send_voxel(15'd1, (i == 19), 0);
    drain(0, 1'b0, 1'b0);
    lit_en = 1'b0;

    // Randomised frames with gaps, restarts, backpressure and ignored starts.
    for (int f = 0; f < 30; f++) begin
      start_frame($urandom_range(0, 1) == 1, VOX_W'($urandom));
      nv = $urandom_range(1, 20);
      for (int i = 0; i < nv; i++) begin
        if (i != 0 && $urandom_range(0, 11) == 0)
          start_frame($urandom_range(0, 1) == 1, VOX_W'($urandom));
        send_voxel(VOX_W'($urandom), (i == nv - 1), $urandom_range(0, 2));
      end
      drain($urandom_range(0, 4), 1'b1, 1'b0);
    end

    repeat (2) cycle(a);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
